// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared constants and state encoding for the 16-bit CPU pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int          WORD_W     = 16;
    localparam logic [15:0] RESET_PC   = 16'h0000;
    localparam logic [15:0] NOP_INSTR  = 16'h0000;
    localparam logic [3:0]  HLT_OPCODE = 4'hF;

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } fetch_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_id_reg
// Description : IF/ID pipeline register with hold, bubble-insert and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              bubble,
    input  logic [WORD_W-1:0] d_instr,
    input  logic [WORD_W-1:0] d_pc_plus1,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] pc_plus1,
    output logic              valid
);

    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_pc_plus1;
    logic              r_valid;

    // Bubble outranks hold so a squash is never lost behind a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr    <= NOP_INSTR;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
        end else if (bubble) begin
            r_instr    <= NOP_INSTR;
            r_valid    <= 1'b0;
        end else if (!hold) begin
            r_instr    <= d_instr;
            r_pc_plus1 <= d_pc_plus1;
            r_valid    <= 1'b1;
        end
    end

    assign instr    = r_instr;
    assign pc_plus1 = r_pc_plus1;
    assign valid    = r_valid;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage: PC, IM interface, IF/ID capture,
//               stall/flush handling and HLT detection.
//               Optional macro IF_PERF_CNT_EN adds fetch/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = cpu_pkg::RESET_PC,
    parameter logic [WORD_W-1:0] NOP_INSTR  = cpu_pkg::NOP_INSTR,
    parameter logic [3:0]        HLT_OPCODE = cpu_pkg::HLT_OPCODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [WORD_W-1:0] branch_tgt,
    input  logic [WORD_W-1:0] im_instr,
    output logic [WORD_W-1:0] im_addr,
    output logic              im_rd_en,
    output logic [WORD_W-1:0] instr_IF_ID,
    output logic [WORD_W-1:0] pc_plus1_IF_ID,
    output logic              valid_IF_ID,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       stall_cnt,
`endif
    output logic              hlt_fetched
);

    fetch_state_e      r_state;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] w_pc_plus1;
    logic              w_normal;
    logic              w_hlt_in;
    logic              w_bubble;

    assign w_pc_plus1 = r_pc + 16'd1;
    assign w_hlt_in   = (im_instr[15:12] == HLT_OPCODE);
    assign w_normal   = (r_state == ST_FETCH) && !stall && !flush;
    // In HALT the stage drains: the HLT leaves IF/ID after one cycle.
    assign w_bubble   = flush || ((r_state == ST_HALT) && !stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_state <= ST_FETCH;
        end else if (flush) begin
            r_pc    <= branch_tgt;
            r_state <= ST_FETCH;
        end else if (w_normal) begin
            if (w_hlt_in) begin
                r_state <= ST_HALT;
            end else begin
                r_pc    <= w_pc_plus1;
            end
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .hold       (stall),
        .bubble     (w_bubble),
        .d_instr    (im_instr),
        .d_pc_plus1 (w_pc_plus1),
        .instr      (instr_IF_ID),
        .pc_plus1   (pc_plus1_IF_ID),
        .valid      (valid_IF_ID)
    );

    assign im_addr     = r_pc;
    assign im_rd_en    = (r_state == ST_FETCH) && !stall && !rst;
    assign hlt_fetched = valid_IF_ID && (instr_IF_ID[15:12] == HLT_OPCODE);

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_normal && (r_fetch_cnt != 32'hFFFF_FFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if ((r_state == ST_FETCH) && stall && !flush && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign stall_cnt = r_stall_cnt;
`endif

endmodule : if_fetch_unit
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for if_fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] branch_tgt = 16'h0000;
    logic [15:0] im_instr = 16'h0000;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] instr_IF_ID;
    logic [15:0] pc_plus1_IF_ID;
    logic        valid_IF_ID;
    logic        hlt_fetched;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    logic [15:0] mem [0:65535];

    if_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .flush          (flush),
        .branch_tgt     (branch_tgt),
        .im_instr       (im_instr),
        .im_addr        (im_addr),
        .im_rd_en       (im_rd_en),
        .instr_IF_ID    (instr_IF_ID),
        .pc_plus1_IF_ID (pc_plus1_IF_ID),
        .valid_IF_ID    (valid_IF_ID),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt      (fetch_cnt),
        .stall_cnt      (stall_cnt),
`endif
        .hlt_fetched    (hlt_fetched)
    );

    always #5 clk = ~clk;

    // Instruction memory latches while clk is low.
    always @(negedge clk) begin
        if (im_rd_en) im_instr <= mem[im_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string name, input logic [15:0] e_instr,
                            input logic [15:0] e_pp1, input logic e_valid,
                            input logic [15:0] e_addr);
        checks++;
        if (instr_IF_ID !== e_instr || pc_plus1_IF_ID !== e_pp1 ||
            valid_IF_ID !== e_valid || im_addr !== e_addr) begin
            failures++;
            $display("FAIL %s: got instr=%h pp1=%h valid=%b addr=%h, want instr=%h pp1=%h valid=%b addr=%h",
                     name, instr_IF_ID, pc_plus1_IF_ID, valid_IF_ID, im_addr,
                     e_instr, e_pp1, e_valid, e_addr);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        chk_ifid("reset_state", 16'h0000, 16'h0000, 1'b0, 16'h0000);
        checks++;
        if (im_rd_en !== 1'b0 || hlt_fetched !== 1'b0) begin
            failures++;
            $display("FAIL reset_rd_en: got rd_en=%b hlt=%b, want 0 0", im_rd_en, hlt_fetched);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (im_rd_en !== 1'b1) begin
            failures++;
            $display("FAIL rd_en_after_reset: got %b want 1", im_rd_en);
        end
    endtask

    task automatic test_free_run_hlt();
        logic [15:0] exp_i [0:3];
        exp_i[0] = 16'h1111; exp_i[1] = 16'h2222; exp_i[2] = 16'h3333; exp_i[3] = 16'hF000;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("free_run", exp_i[i], 16'(i + 1), 1'b1, 16'(i + 1));
        end
        tick();
        chk_ifid("hlt_capture", 16'hF000, 16'h0004, 1'b1, 16'h0003);
        checks++;
        if (hlt_fetched !== 1'b1 || im_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL hlt_flag: got hlt=%b rd_en=%b want 1 0", hlt_fetched, im_rd_en);
        end
        tick();
        chk_ifid("hlt_drain", 16'h0000, 16'h0004, 1'b0, 16'h0003);
        checks++;
        if (hlt_fetched !== 1'b0) begin
            failures++;
            $display("FAIL hlt_once: got hlt=%b want 0", hlt_fetched);
        end
        begin
            int bad = 0;
            for (int i = 0; i < 20; i++) begin
                tick();
                if (im_addr !== 16'h0003 || im_rd_en !== 1'b0 || valid_IF_ID !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL halt_hold: got %0d bad cycles of 20, want 0", bad);
            end
        end
        // Leave HALT via flush.
        flush = 1'b1; branch_tgt = 16'h0010;
        tick();
        flush = 1'b0;
        chk_ifid("halt_flush", 16'h0000, 16'h0004, 1'b0, 16'h0010);
        tick();
        chk_ifid("halt_refetch", 16'h1010, 16'h0011, 1'b1, 16'h0011);
    endtask

    task automatic test_stall();
        flush = 1'b1; branch_tgt = 16'h0004;
        tick();
        flush = 1'b0;
        tick();
        chk_ifid("pre_stall", 16'h1004, 16'h0005, 1'b1, 16'h0005);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ifid("stall_hold", 16'h1004, 16'h0005, 1'b1, 16'h0005);
            checks++;
            if (im_rd_en !== 1'b0) begin
                failures++;
                $display("FAIL stall_rd_en: got %b want 0", im_rd_en);
            end
        end
        stall = 1'b0;
        tick();
        chk_ifid("stall_resume5", 16'h1005, 16'h0006, 1'b1, 16'h0006);
        tick();
        chk_ifid("stall_resume6", 16'h1006, 16'h0007, 1'b1, 16'h0007);
    endtask

    task automatic test_flush_over_stall();
        stall = 1'b1; flush = 1'b1; branch_tgt = 16'h0040;
        tick();
        stall = 1'b0; flush = 1'b0;
        chk_ifid("flush_stall", 16'h0000, 16'h0007, 1'b0, 16'h0040);
        tick();
        chk_ifid("flush_target", 16'h1040, 16'h0041, 1'b1, 16'h0041);
    endtask

    task automatic test_wrap();
        flush = 1'b1; branch_tgt = 16'hFFFF;
        tick();
        flush = 1'b0;
        tick();
        chk_ifid("pc_wrap", 16'h1FFF, 16'h0000, 1'b1, 16'h0000);
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; flush = 1'b1; stall = 1'b1; branch_tgt = 16'h1234;
        tick();
        chk_ifid("reset_mid", 16'h0000, 16'h0000, 1'b0, 16'h0000);
        checks++;
        if (im_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_rd_en: got %b want 0", im_rd_en);
        end
`ifdef IF_PERF_CNT_EN
        checks++;
        if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_cnt: got fetch=%0d stall=%0d want 0 0", fetch_cnt, stall_cnt);
        end
`endif
        rst = 1'b0; flush = 1'b0; stall = 1'b0;
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        tick();
        tick();
        stall = 1'b1;
        tick();
        stall = 1'b0;
        checks++;
        if (fetch_cnt !== 32'd2 || stall_cnt !== 32'd1) begin
            failures++;
            $display("FAIL perf_cnt: got fetch=%0d stall=%0d want 2 1", fetch_cnt, stall_cnt);
        end
    endtask
`endif

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = {4'h1, 12'(a)};
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'hF000;
        test_reset();
        test_free_run_hlt();
        test_stall();
        test_flush_over_stall();
        test_wrap();
        test_reset_mid();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_if_fetch_unit
`default_nettype wire

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the 16-bit, 5-stage pipelined CPU.
- Owns the PC and drives addr/rd_en into the instruction memory, which latches while clk is low.
- Registers the returned word into the IF/ID pipeline register.
- Handles hazard stalls, branch/jump redirects (flush) and HLT detection.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0000, bubble word inserted into IF/ID on flush or reset.
- HLT_OPCODE, 4'hF, value of instr[15:12] that marks HLT.

Ports:
- clk  in  1  system clock; IM latches on clk low, all state here updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  branch resolved taken: redirect to branch_tgt.
- branch_tgt  in  16  redirect target.
- im_instr  in  16  word from instruction memory.
- im_addr  out  16  address to instruction memory (= PC).
- im_rd_en  out  1  read enable to instruction memory.
- instr_IF_ID  out  16  fetched instruction.
- pc_plus1_IF_ID  out  16  PC+1 of that instruction.
- valid_IF_ID  out  1  IF/ID holds a real instruction.
- hlt_fetched  out  1  HLT sitting in IF/ID and valid.

Behaviour:
- Reset (rst=1 at a rising edge):
  - PC=RESET_PC; instr_IF_ID=NOP_INSTR; pc_plus1_IF_ID=0; valid_IF_ID=0.
  - State=FETCH; im_rd_en=0 during the reset cycle.
  - Reset mid-operation discards any flush or stall pending that cycle.
- im_addr is always PC.
- im_rd_en=1 in FETCH when not stalled and not rst; 0 in HALT and when stall=1, so the IM output holds.
- Fetch latency: one cycle. Address presented after edge N; im_instr is sampled into IF/ID at edge N+1.
- States:
  - FETCH, normal cycle (no stall, no flush): PC<=PC+1 (16-bit, 16'hFFFF wraps to 16'h0000); instr_IF_ID<=im_instr; pc_plus1_IF_ID<=PC+1; valid_IF_ID<=1.
  - FETCH -> HALT when the word being captured has im_instr[15:12]==HLT_OPCODE and there is no flush and no stall. The HLT is captured normally. PC is not advanced and stays pointing at the HLT.
  - HALT: PC, IF/ID and rd_en are frozen. The next IF/ID update after the HLT capture is a bubble (valid=0, NOP_INSTR), so HLT appears in IF/ID exactly once.
  - HALT -> FETCH only on flush, since a HLT fetched on a wrong path is squashed.
- stall=1, no flush: PC, IF/ID and state hold; valid is unchanged.
- flush=1: PC<=branch_tgt; instr_IF_ID<=NOP_INSTR; valid_IF_ID<=0; state<=FETCH. This applies in any state.
- flush and stall together: flush wins.
- hlt_fetched = valid_IF_ID & (instr_IF_ID[15:12]==HLT_OPCODE), combinational from IF/ID.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_cnt[31:0] and stall_cnt[31:0], both cleared on rst.
  - fetch_cnt increments on each normal capture with valid=1.
  - stall_cnt increments on each cycle with stall=1 and flush=0 in FETCH.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cpu_pkg holds HLT_OPCODE, NOP_INSTR, RESET_PC, the state encoding (FETCH=1'b0, HALT=1'b1) and the 16-bit word width constant.
- One natural sub-module, if_id_reg: the IF/ID register with hold, bubble-insert and reset controls. It is reused by later pipeline-register work.

Test Plan:
- Reset then free-run over IM words 0..3 = 1111, 2222, 3333, F000:
  - im_addr runs 0,1,2,3.
  - instr_IF_ID = 1111, 2222, 3333, F000 on successive edges.
  - hlt_fetched=1 for one cycle; PC frozen at 3; the next cycle shows valid=0.
- stall for 3 cycles at PC=5: im_addr=5, rd_en=0 and IF/ID unchanged for all 3 cycles; fetch resumes at 5 then 6.
- flush with branch_tgt=16'h0040 while stall=1:
  - Next edge: PC=0040, valid_IF_ID=0, instr_IF_ID=0000.
  - The following edge captures mem[0040] with pc_plus1=0041.
- PC=16'hFFFF, normal fetch: pc_plus1_IF_ID=0000 and next im_addr=0000.
- In HALT, flush to 0010: returns to FETCH and fetches mem[0010]. In HALT without flush, PC holds for 20 cycles.
- rst asserted mid-stream together with flush: PC=RESET_PC and IF/ID is a bubble. With IF_PERF_CNT_EN, both counters read 0.
